// File: rtl/serial_adder_param.sv
// Bit-serial adder that sums BITS_PER_CYCLE bits per clock, LSB first, with valid/ready handshakes.
// Define SERIAL_ADDER_SUB_EN to add the sub_i port and subtract mode (a - b - borrow-in).
module serial_adder_param #(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             c_i,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub_i,
`endif
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             c_o,
    output logic             busy_o
);

    localparam int N     = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(N + 1);

    generate
        if (WIDTH < 2 || BITS_PER_CYCLE < 1 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_cfg
            $error("serial_adder_param: BITS_PER_CYCLE must divide WIDTH and WIDTH must be >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t                    state;
    state_t                    state_next;
    logic [CNT_W-1:0]          count;
    logic [WIDTH-1:0]          a_sr;
    logic [WIDTH-1:0]          b_sr;
    logic [WIDTH-1:0]          sum_sr;
    logic                      carry;
    logic [BITS_PER_CYCLE-1:0] chain_sum;
    logic [BITS_PER_CYCLE:0]   chain_c;
    logic [WIDTH-1:0]          a_shift;
    logic [WIDTH-1:0]          b_shift;
    logic [WIDTH-1:0]          sum_shift;
    logic [WIDTH-1:0]          b_load;
    logic                      c_load;
    logic                      last_shift;

    // Subtraction reuses the adder: a + ~b + ~borrow_in equals a - b - borrow_in.
`ifdef SERIAL_ADDER_SUB_EN
    assign b_load = sub_i ? ~b_i : b_i;
    assign c_load = sub_i ? ~c_i : c_i;
`else
    assign b_load = b_i;
    assign c_load = c_i;
`endif

    always_comb begin
        chain_sum  = '0;
        chain_c    = '0;
        chain_c[0] = carry;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            chain_sum[i]   = a_sr[i] ^ b_sr[i] ^ chain_c[i];
            chain_c[i+1]   = (a_sr[i] & b_sr[i]) | (chain_c[i] & (a_sr[i] ^ b_sr[i]));
        end
        a_shift   = a_sr >> BITS_PER_CYCLE;
        b_shift   = b_sr >> BITS_PER_CYCLE;
        sum_shift = sum_sr >> BITS_PER_CYCLE;
        sum_shift[WIDTH-1 -: BITS_PER_CYCLE] = chain_sum;
    end

    assign last_shift = (state == SHIFT) && (count == CNT_W'(N - 1));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid_i) state_next = SHIFT;
            SHIFT:   if (last_shift) state_next = DONE;
            DONE:    if (out_ready_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Result outputs are only written on the final shift so they stay stable outside DONE entry.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state  <= IDLE;
            count  <= '0;
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            sum_o  <= '0;
            c_o    <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (in_valid_i) begin
                        a_sr   <= a_i;
                        b_sr   <= b_load;
                        carry  <= c_load;
                        count  <= '0;
                        sum_sr <= '0;
                    end
                end
                SHIFT: begin
                    a_sr   <= a_shift;
                    b_sr   <= b_shift;
                    sum_sr <= sum_shift;
                    carry  <= chain_c[BITS_PER_CYCLE];
                    count  <= count + 1'b1;
                    if (last_shift) begin
                        sum_o <= sum_shift;
                        c_o   <= chain_c[BITS_PER_CYCLE];
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready_o  = (state == IDLE);
    assign out_valid_o = (state == DONE);
    assign busy_o      = (state != IDLE);

endmodule

// File: tb/tb_serial_adder_param.sv
// Directed bench for serial_adder_param: one instance with BITS_PER_CYCLE=1, one with 4.
// Subtract-mode steps are compiled in when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder_param;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       c = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    logic       sub = 1'b0;
`endif
    logic       in_valid1 = 1'b0;
    logic       in_ready1;
    logic       out_valid1;
    logic       out_ready1 = 1'b0;
    logic [7:0] sum1;
    logic       co1;
    logic       busy1;
    logic       in_valid4 = 1'b0;
    logic       in_ready4;
    logic       out_valid4;
    logic       out_ready4 = 1'b0;
    logic [7:0] sum4;
    logic       co4;
    logic       busy4;

    int checks = 0;
    int errors = 0;
    int lat;

    always #5 clk_i = ~clk_i;

    serial_adder_param #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut1 (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (in_valid1),
        .in_ready_o  (in_ready1),
        .a_i         (a),
        .b_i         (b),
        .c_i         (c),
`ifdef SERIAL_ADDER_SUB_EN
        .sub_i       (sub),
`endif
        .out_valid_o (out_valid1),
        .out_ready_i (out_ready1),
        .sum_o       (sum1),
        .c_o         (co1),
        .busy_o      (busy1)
    );

    serial_adder_param #(.WIDTH(8), .BITS_PER_CYCLE(4)) dut4 (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (in_valid4),
        .in_ready_o  (in_ready4),
        .a_i         (a),
        .b_i         (b),
        .c_i         (c),
`ifdef SERIAL_ADDER_SUB_EN
        .sub_i       (sub),
`endif
        .out_valid_o (out_valid4),
        .out_ready_i (out_ready4),
        .sum_o       (sum4),
        .c_o         (co4),
        .busy_o      (busy4)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("[TB] check %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents one operand set for a single cycle, then counts cycles until out_valid (bounded).
    task automatic apply_stimulus(input bit wide, input logic [7:0] av, input logic [7:0] bv,
                                  input logic cv, output int cycles);
        a = av;
        b = bv;
        c = cv;
        if (wide) in_valid4 = 1'b1;
        else in_valid1 = 1'b1;
        cycles = 0;
        do begin
            tick();
            cycles++;
            in_valid1 = 1'b0;
            in_valid4 = 1'b0;
        end while (!(wide ? out_valid4 : out_valid1) && cycles < 40);
    endtask

    task automatic release_result(input bit wide, input string tag);
        if (wide) out_ready4 = 1'b1;
        else out_ready1 = 1'b1;
        tick();
        out_ready1 = 1'b0;
        out_ready4 = 1'b0;
        check_output({tag, "_valid_drop"}, wide ? out_valid4 : out_valid1, 0);
        check_output({tag, "_ready_back"}, wide ? in_ready4 : in_ready1, 1);
    endtask

    initial begin
        tick();
        tick();
        check_output("rst_sum", sum1, 8'h00);
        check_output("rst_co", co1, 0);
        check_output("rst_valid", out_valid1, 0);
        check_output("rst_ready", in_ready1, 1);
        check_output("rst_busy", busy1, 0);
        rst_ni = 1'b1;
        tick();

        // T1: basic add and latency
        apply_stimulus(0, 8'h5A, 8'h33, 0, lat);
        check_output("t1_lat", lat, 9);
        check_output("t1_sum", sum1, 8'h8D);
        check_output("t1_co", co1, 0);
        check_output("t1_busy", busy1, 1);
        check_output("t1_ready", in_ready1, 0);
        tick();
        check_output("t1_valid_hold", out_valid1, 1);
        release_result(0, "t1");
        check_output("t1_sum_idle", sum1, 8'h8D);

        // T2: carry out of MSB, carry-in only
        apply_stimulus(0, 8'hFF, 8'h01, 0, lat);
        check_output("t2a_sum", sum1, 8'h00);
        check_output("t2a_co", co1, 1);
        release_result(0, "t2a");
        out_ready1 = 1'b1;
        apply_stimulus(0, 8'hFF, 8'h00, 1, lat);
        check_output("t2b_lat", lat, 9);
        check_output("t2b_sum", sum1, 8'h00);
        check_output("t2b_co", co1, 1);
        tick();
        check_output("t2b_valid_one", out_valid1, 0);
        check_output("t2b_ready", in_ready1, 1);
        out_ready1 = 1'b0;

        // T3: backpressure in DONE, new operands ignored until IDLE
        apply_stimulus(0, 8'h22, 8'h22, 0, lat);
        check_output("t3_first", sum1, 8'h44);
        a = 8'h11;
        b = 8'h00;
        c = 1'b0;
        in_valid1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_output("t3_hold_sum", sum1, 8'h44);
            check_output("t3_hold_ready", in_ready1, 0);
            check_output("t3_hold_valid", out_valid1, 1);
        end
        out_ready1 = 1'b1;
        tick();
        out_ready1 = 1'b0;
        check_output("t3_idle", in_ready1, 1);
        check_output("t3_idle_busy", busy1, 0);
        tick();
        in_valid1 = 1'b0;
        check_output("t3_accept", busy1, 1);
        lat = 1;
        while (!out_valid1 && lat < 40) begin
            tick();
            lat++;
        end
        check_output("t3_lat", lat, 9);
        check_output("t3_sum", sum1, 8'h11);
        check_output("t3_co", co1, 0);
        release_result(0, "t3");

        // T4: reset mid-operation
        a = 8'hAA;
        b = 8'h55;
        in_valid1 = 1'b1;
        tick();
        in_valid1 = 1'b0;
        tick();
        tick();
        tick();
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        check_output("t4_ready", in_ready1, 1);
        check_output("t4_valid", out_valid1, 0);
        check_output("t4_sum", sum1, 8'h00);
        check_output("t4_co", co1, 0);
        check_output("t4_busy", busy1, 0);
        apply_stimulus(0, 8'h01, 8'h01, 0, lat);
        check_output("t4_lat", lat, 9);
        check_output("t4_after", sum1, 8'h02);
        release_result(0, "t4");

        // T5: four bits per cycle
        apply_stimulus(1, 8'hF0, 8'h10, 0, lat);
        check_output("t5_lat", lat, 3);
        check_output("t5_sum", sum4, 8'h00);
        check_output("t5_co", co4, 1);
        release_result(1, "t5a");
        apply_stimulus(1, 8'h8F, 8'h01, 0, lat);
        check_output("t5_nibble_carry", sum4, 8'h90);
        check_output("t5_nibble_co", co4, 0);
        release_result(1, "t5b");

`ifdef SERIAL_ADDER_SUB_EN
        // T6: subtract mode
        sub = 1'b1;
        apply_stimulus(0, 8'h10, 8'h01, 0, lat);
        check_output("t6a_sum", sum1, 8'h0F);
        check_output("t6a_co", co1, 1);
        release_result(0, "t6a");
        apply_stimulus(0, 8'h01, 8'h02, 0, lat);
        check_output("t6b_sum", sum1, 8'hFF);
        check_output("t6b_co", co1, 0);
        release_result(0, "t6b");
        apply_stimulus(0, 8'h10, 8'h01, 1, lat);
        check_output("t6c_borrow_in", sum1, 8'h0E);
        release_result(0, "t6c");
        sub = 1'b0;
        apply_stimulus(0, 8'h10, 8'h01, 0, lat);
        check_output("t6d_add_again", sum1, 8'h11);
        release_result(0, "t6d");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
